// File: rtl/inst_sram_like_bridge.sv
// Instruction-side SRAM-like to AXI4 read bridge: in-order 64-bit fetch pairs, flush cancellation.
// Optional INST_BRIDGE_RRESP_ERR_EN reports a per-fetch bus error on inst_sram_err_o.
module inst_sram_like_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [3:0]  ARID            = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_sram_req_i,
  input  logic [31:0] inst_sram_addr_i,
  output logic        inst_sram_addr_ok_o,
  output logic        inst_sram_data_ok_o,
  output logic [63:0] inst_sram_rdata_o,
  output logic        inst_sram_err_o,
  input  logic        excep_flush_i,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  typedef enum logic [1:0] {AR_IDLE, AR_SEND, AR_SPLIT} ar_state_e;
  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  ar_state_e   ar_state;
  logic [2:0]  out_cnt, cancel_cnt;
  logic [31:0] lo;
  logic [3:0]  split_q;
  logic [1:0]  wr_ptr, rd_ptr;
  logic        second, err_acc;
  logic        accept, beat, final_beat, beat_err, unused_in;

  assign arid    = ARID;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;

`ifdef INST_BRIDGE_RRESP_ERR_EN
  assign beat_err  = (rresp != 2'b00);
  assign unused_in = ^rid;
`else
  assign beat_err  = 1'b0;
  assign unused_in = ^{rid, rresp};
`endif

  assign accept = rst_n & inst_sram_req_i & ~excep_flush_i & (out_cnt < MAX_CNT) & (ar_state == AR_IDLE);
  assign inst_sram_addr_ok_o = accept;
  assign beat       = rvalid & rready;
  // A split fetch arrives as two single-beat responses, each with rlast set.
  assign final_beat = beat & rlast & (~split_q[rd_ptr] | second);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ar_state            <= AR_IDLE;
      arvalid             <= 1'b0;
      araddr              <= 32'h0;
      arlen               <= 8'h0;
      rready              <= 1'b0;
      out_cnt             <= 3'd0;
      cancel_cnt          <= 3'd0;
      lo                  <= 32'h0;
      split_q             <= 4'h0;
      wr_ptr              <= 2'd0;
      rd_ptr              <= 2'd0;
      second              <= 1'b0;
      err_acc             <= 1'b0;
      inst_sram_data_ok_o <= 1'b0;
      inst_sram_rdata_o   <= 64'h0;
      inst_sram_err_o     <= 1'b0;
    end else begin
      rready <= 1'b1;

      case (ar_state)
        AR_IDLE: if (accept) begin
          araddr   <= inst_sram_addr_i;
          arlen    <= (inst_sram_addr_i[11:2] == 10'h3FF) ? 8'd0 : 8'd1;
          arvalid  <= 1'b1;
          ar_state <= AR_SEND;
        end
        AR_SEND: if (arready) begin
          // Last word of a 4 KB page: second word goes out as its own single-beat read.
          if (araddr[11:2] == 10'h3FF) begin
            araddr   <= araddr + 32'd4;
            ar_state <= AR_SPLIT;
          end else begin
            arvalid  <= 1'b0;
            ar_state <= AR_IDLE;
          end
        end
        AR_SPLIT: if (arready) begin
          arvalid  <= 1'b0;
          ar_state <= AR_IDLE;
        end
        default: ar_state <= AR_IDLE;
      endcase

      if (accept) begin
        split_q[wr_ptr] <= (inst_sram_addr_i[11:2] == 10'h3FF);
        wr_ptr          <= wr_ptr + 2'd1;
      end
      if (final_beat) rd_ptr <= rd_ptr + 2'd1;

      case ({accept, final_beat})
        2'b10:   out_cnt <= out_cnt + 3'd1;
        2'b01:   out_cnt <= out_cnt - 3'd1;
        default: out_cnt <= out_cnt;
      endcase

      inst_sram_data_ok_o <= 1'b0;
      inst_sram_err_o     <= 1'b0;
      if (beat) begin
        if (final_beat) begin
          second  <= 1'b0;
          err_acc <= 1'b0;
          if (cancel_cnt == 3'd0) begin
            inst_sram_data_ok_o <= 1'b1;
            inst_sram_rdata_o   <= {rdata, lo};
            inst_sram_err_o     <= err_acc | beat_err;
          end
        end else begin
          second  <= 1'b1;
          lo      <= rdata;
          err_acc <= err_acc | beat_err;
        end
      end

      // A fetch finishing in the flush cycle still returns; everything else in flight is dropped.
      if (excep_flush_i)
        cancel_cnt <= out_cnt - {2'b00, final_beat};
      else if (final_beat && cancel_cnt != 3'd0)
        cancel_cnt <= cancel_cnt - 3'd1;
    end
  end
endmodule

// File: tb/tb_inst_sram_like_bridge.sv
// Randomised bench for inst_sram_like_bridge: AXI slave model, fetch-level reference model, scoreboard.
module tb_inst_sram_like_bridge;
  localparam int MAX = 2;
`ifdef INST_BRIDGE_RRESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk, rst_n, req, addr_ok, data_ok, err, flush;
  logic [31:0] addr;
  logic [63:0] rdata_o;
  logic [3:0]  arid, rid;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;

  inst_sram_like_bridge #(.MAX_OUTSTANDING(MAX), .ARID(4'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_sram_req_i(req), .inst_sram_addr_i(addr), .inst_sram_addr_ok_o(addr_ok),
    .inst_sram_data_ok_o(data_ok), .inst_sram_rdata_o(rdata_o), .inst_sram_err_o(err),
    .excep_flush_i(flush),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct { logic [63:0] data; int beats; logic err; logic canc; } pend_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [63:0] data; logic err; int due; } exp_t;

  pend_t pend[$];
  ar_t   ar_exp[$], r_q[$];
  exp_t  exp_q[$];

  int checks = 0, errors = 0, cyc = 0, r_beat = 0, n_dok = 0;
  int ar_delay = 0, r_pct = 100, err_pct = 0;
  bit ar_rand = 0;
  logic [63:0] last_rdata;
  logic        last_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1C00_0000) return 32'h0280_0404;
    if (a == 32'h1C00_0004) return 32'h0340_0000;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] a;
    a = 32'h1C00_0000 + 32'($urandom_range(0, 15) << 12);
    if ($urandom_range(0, 3) == 0) a[11:0] = 12'hFFC;
    else a[11:2] = 10'($urandom_range(0, 1023));
    return a;
  endfunction

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  // AXI slave driver: acts after the stimulus driver so it sees the current rst_n.
  initial begin
    int ar_wait;
    ar_wait = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        arready = 0; rvalid = 0; ar_wait = 0;
      end else begin
        if (arvalid) begin
          arready = ar_rand ? ($urandom_range(0, 99) < 60) : (ar_wait >= ar_delay);
          ar_wait = arready ? 0 : ar_wait + 1;
        end else begin
          arready = 0; ar_wait = 0;
        end
        if (r_q.size() != 0 && $urandom_range(0, 99) < r_pct) begin
          rvalid = 1;
          rdata  = mem_word(r_q[0].addr + 32'(r_beat * 4));
          rlast  = (r_beat == int'(r_q[0].len));
          rresp  = ($urandom_range(0, 99) < err_pct) ? 2'b10 : 2'b00;
        end else begin
          rvalid = 0; rdata = $urandom; rlast = 0; rresp = 0;
        end
      end
    end
  end

  // Reference model: fetches are tracked as whole transactions, each needing two data words.
  initial begin
    pend_t h;
    ar_t   a;
    logic  exp_aok;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete(); ar_exp.delete(); r_q.delete(); exp_q.delete(); r_beat = 0;
      end else begin
        exp_aok = req & ~flush & (pend.size() < MAX) & (ar_exp.size() == 0);
        chk("addr_ok", {63'b0, addr_ok}, {63'b0, exp_aok});
        chk("arvalid", {63'b0, arvalid}, {63'b0, ar_exp.size() != 0});
        if (arvalid && ar_exp.size() != 0) begin
          chk("araddr", {32'b0, araddr}, {32'b0, ar_exp[0].addr});
          chk("arlen", {56'b0, arlen}, {56'b0, ar_exp[0].len});
          if (arready) begin a = ar_exp.pop_front(); r_q.push_back(a); end
        end
        if (rvalid && rready) begin
          if (pend.size() == 0 || r_q.size() == 0) fail("beat_without_fetch");
          else begin
            if (r_beat == int'(r_q[0].len)) begin void'(r_q.pop_front()); r_beat = 0; end
            else r_beat++;
            h = pend[0];
            h.beats++;
            h.err |= (rresp != 2'b00);
            pend[0] = h;
            if (h.beats == 2) begin
              void'(pend.pop_front());
              if (!h.canc) exp_q.push_back('{data: h.data, err: h.err & ERR_EN, due: cyc + 1});
            end
          end
        end
        if (flush)
          foreach (pend[i]) begin h = pend[i]; h.canc = 1; pend[i] = h; end
        if (addr_ok && req) begin
          pend.push_back('{data: {mem_word(addr + 32'd4), mem_word(addr)}, beats: 0, err: 0, canc: 0});
          if (addr[11:2] == 10'h3FF) begin
            ar_exp.push_back('{addr: addr, len: 8'd0});
            ar_exp.push_back('{addr: addr + 32'd4, len: 8'd0});
          end else ar_exp.push_back('{addr: addr, len: 8'd1});
        end
      end
    end
  end

  // Monitor: every data_ok pops the oldest surviving fetch.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (data_ok) begin
          n_dok++; last_rdata = rdata_o; last_err = err;
          if (exp_q.size() == 0) fail("unexpected_data_ok");
          else begin
            e = exp_q.pop_front();
            chk("rdata", rdata_o, e.data);
            chk("err", {63'b0, err}, {63'b0, e.err});
            chk("data_ok_cycle", 64'(cyc), 64'(e.due));
          end
        end else chk("err_idle", {63'b0, err}, 64'd0);
      end
    end
  end

  task automatic check_reset();
    chk("rst_addr_ok", {63'b0, addr_ok}, 64'd0);
    chk("rst_data_ok", {63'b0, data_ok}, 64'd0);
    chk("rst_rdata", rdata_o, 64'd0);
    chk("rst_err", {63'b0, err}, 64'd0);
    chk("rst_arvalid", {63'b0, arvalid}, 64'd0);
    chk("rst_araddr", {32'b0, araddr}, 64'd0);
    chk("rst_arlen", {56'b0, arlen}, 64'd0);
    chk("rst_rready", {63'b0, rready}, 64'd0);
  endtask

  task automatic fetch(input logic [31:0] a);
    int k;
    @(posedge clk); #1; req = 1; addr = a;
    @(negedge clk);
    k = 0;
    while (!addr_ok && k < 300) begin @(negedge clk); k++; end
    if (!addr_ok) fail("fetch_accept_timeout");
    @(posedge clk); #1; req = 0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((pend.size() != 0 || exp_q.size() != 0 || ar_exp.size() != 0) && k < 3000) begin
      @(negedge clk); k++;
    end
    if (k >= 3000) fail("drain_timeout");
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, k, d0, n_acc;
    logic [31:0] pc;
    rst_n = 0; req = 1; addr = 32'h1C00_0000; flush = 0;
    repeat (3) @(posedge clk);
    #1; check_reset();
    rst_n = 1; req = 0;
    repeat (2) @(posedge clk);
    #1; chk("rready_after_reset", {63'b0, rready}, 64'd1);

    // Single fetch, zero-wait slave: data_ok four cycles after acceptance.
    @(posedge clk); #1; req = 1; addr = 32'h1C00_0000;
    @(negedge clk); chk("t1_addr_ok", {63'b0, addr_ok}, 64'd1); t0 = cyc;
    @(posedge clk); #1; req = 0;
    @(negedge clk);
    chk("t1_arvalid", {63'b0, arvalid}, 64'd1);
    chk("t1_araddr", {32'b0, araddr}, 64'h1C00_0000);
    chk("t1_arlen", {56'b0, arlen}, 64'd1);
    k = 0;
    while (!data_ok && k < 20) begin @(negedge clk); k++; end
    chk("t1_latency", 64'(cyc - t0), 64'd4);
    chk("t1_rdata", rdata_o, 64'h0340_0000_0280_0404);
    wait_idle();

    // Constant request, slow AR and R channels.
    ar_delay = 3; r_pct = 30; pc = 32'h1C00_0100; n_acc = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1; req = 1; addr = pc;
      @(negedge clk);
      if (addr_ok) begin pc += 32'd8; n_acc++; end
    end
    @(posedge clk); #1; req = 0; r_pct = 100;
    wait_idle();
    chk("t2_progress", {63'b0, n_acc > 3}, 64'd1);
    ar_delay = 0;

    // Page-crossing fetch: two single-beat reads, one data_ok.
    d0 = n_dok;
    fetch(32'h1C00_0FFC);
    wait_idle();
    chk("t3_dok_count", 64'(n_dok - d0), 64'd1);
    chk("t3_rdata", last_rdata, {mem_word(32'h1C00_1000), mem_word(32'h1C00_0FFC)});

    // Flush with two fetches in flight, one still in its AR phase.
    r_pct = 0; d0 = n_dok;
    fetch(32'h1C00_1000);
    fetch(32'h1C00_2000);
    flush = 1; req = 1; addr = 32'h1C00_8000;
    @(negedge clk); chk("t4_flush_addr_ok", {63'b0, addr_ok}, 64'd0);
    @(posedge clk); #1; flush = 0; r_pct = 100;
    k = 0;
    @(negedge clk);
    while (!addr_ok && k < 300) begin @(negedge clk); k++; end
    @(posedge clk); #1; req = 0;
    wait_idle();
    chk("t4_dok_count", 64'(n_dok - d0), 64'd1);
    chk("t4_rdata", last_rdata, {mem_word(32'h1C00_8004), mem_word(32'h1C00_8000)});

    // Error response on every beat.
    err_pct = 100;
    fetch(32'h1C00_3000);
    wait_idle();
    chk("t5_err", {63'b0, last_err}, {63'b0, ERR_EN});
    err_pct = 0;

    // Reset while a beat is pending, then a clean fetch.
    r_pct = 0;
    fetch(32'h1C00_4000);
    repeat (3) @(posedge clk);
    #1; rst_n = 0;
    @(posedge clk); #1; check_reset();
    rst_n = 1; r_pct = 100; d0 = n_dok;
    fetch(32'h1C00_5000);
    wait_idle();
    chk("t6_dok_count", 64'(n_dok - d0), 64'd1);
    chk("t6_rdata", last_rdata, {mem_word(32'h1C00_5004), mem_word(32'h1C00_5000)});

    // Random traffic with flushes, stalls and error responses.
    ar_rand = 1; r_pct = 70; err_pct = 10;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      req   = ($urandom_range(0, 1) == 1);
      addr  = rand_pc();
      flush = ($urandom_range(0, 99) < 3);
    end
    @(posedge clk); #1; req = 0; flush = 0; r_pct = 100;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
